// File: rtl/sev_seg_scan_n.sv
// ---------------------------------------------------------------------------
// sev_seg_scan_n
// Multiplexed N-digit hex seven-segment scanner with a double-buffered
// display frame, leading-zero blanking and a PWM brightness control.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   load         one-cycle strobe: capture value/dp/blank_lz into pending
//   value        4*NUM_DIGITS hex nibbles, nibble 0 is the rightmost digit
//   dp           per-digit decimal point request (1 = lit)
//   blank_lz     leading-zero blanking enable (buffered with the frame)
//   brightness   on-time select, sampled live every cycle
//   sev_seg_leds active-low segments {dp,g,f,e,d,c,b,a}, registered
//   led_enable   active-low one-hot digit enable, registered
//   frame_done   one-cycle pulse after the tick that wraps the digit index
// ---------------------------------------------------------------------------
module sev_seg_scan_n #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE_W = 15,
  parameter int DUTY_W     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  input  logic [DUTY_W-1:0]       brightness,
  output logic [7:0]              sev_seg_leds,
  output logic [NUM_DIGITS-1:0]   led_enable,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // One complete display frame: everything a load captures.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    blank_lz;
  } frame_t;

  logic [PRESCALE_W-1:0] prescaler;
  logic [IDX_W-1:0]      idx;
  frame_t                pend;
  frame_t                act;
  logic                  pend_valid;

  logic                  tick;
  logic                  wrap;
  logic                  duty_on;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  zero_above;
  logic [3:0]            nibble;
  logic [7:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] en_nxt;

  // Active-low glyphs {g,f,e,d,c,b,a} for 0-F.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign tick    = &prescaler;
  assign wrap    = tick && (idx == LAST_IDX);
  assign duty_on = (prescaler[PRESCALE_W-1 -: DUTY_W] <= brightness);

  // Scan timing: free-running prescaler, digit index steps once per slot.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
    end
  end

  // Double buffer: loads land in pending; pending moves to active only at a
  // frame wrap, so a frame is never built from two different loads. A load
  // on the wrap cycle itself wins the pending slot and stays valid.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the frame buffers are reset on purpose: after reset the display
    // must show a defined "0" and stale pending data must be discarded.
    if (!reset) begin
      pend       <= '0;
      act        <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (wrap && pend_valid) act <= pend;
      if (load) begin
        pend       <= '{value: value, dp: dp, blank_lz: blank_lz};
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Leading-zero mask: digit i is blank when it and every digit to its left
  // are zero. Digit 0 is never blanked so a zero value still reads "0".
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    blank_vec  = '0;
    zero_above = act.blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above && (act.value[4*i +: 4] == 4'h0);
      blank_vec[i] = zero_above;
    end
  end

  always_comb begin
    nibble  = act.value[4*idx +: 4];
    seg_nxt = 8'hFF;
    en_nxt  = '1;
    if (duty_on) begin
      seg_nxt = {~act.dp[idx], blank_vec[idx] ? 7'h7F : hex_to_seg(nibble)};
      en_nxt  = ~(NUM_DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sev_seg_leds <= 8'hFF;
      led_enable   <= '1;
      frame_done   <= 1'b0;
    end else begin
      sev_seg_leds <= seg_nxt;
      led_enable   <= en_nxt;
      frame_done   <= wrap;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_n.sv
// ---------------------------------------------------------------------------
// tb_sev_seg_scan_n
// Directed bench for sev_seg_scan_n. Main instance: NUM_DIGITS=4,
// PRESCALE_W=4, DUTY_W=3 (16-cycle slot, 64-cycle frame). A second
// NUM_DIGITS=6 instance covers the non-power-of-two index and mid-slot reset.
// Cycle index k counts rising edges since the latest reset release; outputs
// are sampled 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_sev_seg_scan_n;

  localparam int ND = 4;
  localparam int PW = 4;
  localparam int DW = 3;
  localparam int ND6 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            load;
  logic [4*ND-1:0] value;
  logic [ND-1:0]   dp;
  logic            blank_lz;
  logic [DW-1:0]   brightness;
  logic [7:0]      sev_seg_leds;
  logic [ND-1:0]   led_enable;
  logic            frame_done;

  logic             reset6;
  logic             load6;
  logic [4*ND6-1:0] value6;
  logic [ND6-1:0]   dp6;
  logic             blank_lz6;
  logic [7:0]       sev_seg_leds6;
  logic [ND6-1:0]   led_enable6;
  logic             frame_done6;

  sev_seg_scan_n #(.NUM_DIGITS(ND), .PRESCALE_W(PW), .DUTY_W(DW)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp(dp),
    .blank_lz(blank_lz), .brightness(brightness),
    .sev_seg_leds(sev_seg_leds), .led_enable(led_enable),
    .frame_done(frame_done)
  );

  sev_seg_scan_n #(.NUM_DIGITS(ND6), .PRESCALE_W(PW), .DUTY_W(DW)) dut6 (
    .clk(clk), .reset(reset6), .load(load6), .value(value6), .dp(dp6),
    .blank_lz(blank_lz6), .brightness(brightness),
    .sev_seg_leds(sev_seg_leds6), .led_enable(led_enable6),
    .frame_done(frame_done6)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         k;
    logic [3:0] en;
    logic [7:0] seg;
    logic       fd;
  } tvec_t;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blz;
    logic [7:0]  s0, s1, s2, s3;
  } vec_t;

  tvec_t tvecs[10];
  vec_t  vecs[9];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input logic [15:0] v, input logic [3:0] d,
                            input logic b);
    value    = v;
    dp       = d;
    blank_lz = b;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
  endtask

  // Advance until frame_done is sampled high, bounded.
  task automatic sync_frame(output int waited);
    waited = 0;
    do begin
      step(1);
      waited++;
    end while (!frame_done && waited < 300);
    check("sync_frame_seen", frame_done, 1'b1);
  endtask

  // Called right at a frame_done sample: walk the next frame, one sample per
  // digit slot, and compare enables and segments.
  task automatic check_frame(input string tag, input logic [7:0] s0,
                             input logic [7:0] s1, input logic [7:0] s2,
                             input logic [7:0] s3);
    logic [7:0] segs[4];
    logic [3:0] ens[4];
    segs = '{s0, s1, s2, s3};
    ens  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      step(i == 0 ? 1 : 16);
      check($sformatf("%s_d%0d_en", tag, i), led_enable, ens[i]);
      check($sformatf("%s_d%0d_seg", tag, i), sev_seg_leds, segs[i]);
    end
  endtask

  task automatic duty_window(input logic [DW-1:0] b, input int exp_on);
    int on_cnt;
    int bad;
    on_cnt = 0;
    bad    = 0;
    brightness = b;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (led_enable != 4'hF) begin
        on_cnt++;
        if ($countones(~led_enable) != 1) bad++;
      end else if (sev_seg_leds != 8'hFF) begin
        bad++;
      end
    end
    check($sformatf("duty_b%0d_on_cycles", b), on_cnt, exp_on);
    check($sformatf("duty_b%0d_illegal", b), bad, 0);
  endtask

  initial begin
    int waited;
    int k;
    int bad6;
    int fd6_cnt;
    logic [7:0] prev_s3;

    // Scan timing after reset, brightness 7, no load.
    tvecs[0] = '{1,   4'b1110, 8'hC0, 1'b0};
    tvecs[1] = '{15,  4'b1110, 8'hC0, 1'b0};
    tvecs[2] = '{16,  4'b1110, 8'hC0, 1'b0};
    tvecs[3] = '{17,  4'b1101, 8'hC0, 1'b0};
    tvecs[4] = '{33,  4'b1011, 8'hC0, 1'b0};
    tvecs[5] = '{49,  4'b0111, 8'hC0, 1'b0};
    tvecs[6] = '{63,  4'b0111, 8'hC0, 1'b0};
    tvecs[7] = '{64,  4'b0111, 8'hC0, 1'b1};
    tvecs[8] = '{65,  4'b1110, 8'hC0, 1'b0};
    tvecs[9] = '{128, 4'b0111, 8'hC0, 1'b1};

    // Frame loads and the segments expected for digits 0..3.
    vecs[0] = '{16'h12AF, 4'b0100, 1'b0, 8'h8E, 8'h88, 8'h24, 8'hF9};
    vecs[1] = '{16'h3456, 4'b0000, 1'b0, 8'h82, 8'h92, 8'h99, 8'hB0};
    vecs[2] = '{16'h789B, 4'b0000, 1'b0, 8'h83, 8'h90, 8'h80, 8'hF8};
    vecs[3] = '{16'hCDE0, 4'b0000, 1'b0, 8'hC0, 8'h86, 8'hA1, 8'hC6};
    vecs[4] = '{16'h0005, 4'b0000, 1'b1, 8'h92, 8'hFF, 8'hFF, 8'hFF};
    vecs[5] = '{16'h0000, 4'b0000, 1'b1, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
    vecs[6] = '{16'h0300, 4'b0000, 1'b1, 8'hC0, 8'hC0, 8'hB0, 8'hFF};
    vecs[7] = '{16'h0007, 4'b0100, 1'b1, 8'hF8, 8'hFF, 8'h7F, 8'hFF};
    vecs[8] = '{16'h1234, 4'b1001, 1'b1, 8'h19, 8'hB0, 8'hA4, 8'h79};

    reset = 1'b0; load = 1'b0; value = '0; dp = '0; blank_lz = 1'b0;
    brightness = 3'd7;
    reset6 = 1'b0; load6 = 1'b0; value6 = '0; dp6 = '0; blank_lz6 = 1'b0;

    #22;
    check("reset_seg", sev_seg_leds, 8'hFF);
    check("reset_en", led_enable, 4'hF);
    check("reset_fd", frame_done, 1'b0);
    check("reset6_en", led_enable6, 6'h3F);

    @(negedge clk);
    reset = 1'b1;
    k = 0;

    foreach (tvecs[i]) begin
      step(tvecs[i].k - k);
      k = tvecs[i].k;
      check($sformatf("scan_k%0d_en", k), led_enable, tvecs[i].en);
      check($sformatf("scan_k%0d_seg", k), sev_seg_leds, tvecs[i].seg);
      check($sformatf("scan_k%0d_fd", k), frame_done, tvecs[i].fd);
    end

    // Each load happens mid-frame; the old frame must hold until the wrap.
    prev_s3 = 8'hC0;
    foreach (vecs[i]) begin
      load_frame(vecs[i].value, vecs[i].dp, vecs[i].blz);
      sync_frame(waited);
      check($sformatf("v%0d_hold_en", i), led_enable, 4'b0111);
      check($sformatf("v%0d_hold_seg", i), sev_seg_leds, prev_s3);
      check_frame($sformatf("v%0d", i), vecs[i].s0, vecs[i].s1,
                  vecs[i].s2, vecs[i].s3);
      prev_s3 = vecs[i].s3;
    end
    blank_lz = 1'b0;

    duty_window(3'd0, 2);
    duty_window(3'd3, 8);
    duty_window(3'd7, 16);

    // Two loads in one frame, then a third on the wrap edge.
    sync_frame(waited);
    load_frame(16'h1111, 4'b0000, 1'b0);
    step(10);
    load_frame(16'h2222, 4'b0000, 1'b0);
    step(51);
    load_frame(16'h5555, 4'b0000, 1'b0);
    check("wrap_load_aligned_fd", frame_done, 1'b1);
    check_frame("last_wins", 8'hA4, 8'hA4, 8'hA4, 8'hA4);
    sync_frame(waited);
    check_frame("wrap_load", 8'h92, 8'h92, 8'h92, 8'h92);

    // Mid-slot reset discards pending data and restarts the scan.
    load_frame(16'h8888, 4'b1111, 1'b0);
    step(3);
    #2 reset = 1'b0;
    #1;
    check("async_reset_seg", sev_seg_leds, 8'hFF);
    check("async_reset_en", led_enable, 4'hF);
    check("async_reset_fd", frame_done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    sync_frame(waited);
    check("restart_first_wrap_cycles", waited, 64);
    check_frame("after_reset", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    // Six-digit instance: index range and mid-slot async reset.
    @(negedge clk);
    reset6 = 1'b1;
    step(40);
    check("six_k40_en", led_enable6, 6'b111011);
    check("six_k40_seg", sev_seg_leds6, 8'hC0);
    #2 reset6 = 1'b0;
    #1;
    check("six_async_en", led_enable6, 6'h3F);
    check("six_async_seg", sev_seg_leds6, 8'hFF);
    check("six_async_fd", frame_done6, 1'b0);
    @(negedge clk);
    reset6 = 1'b1;
    bad6 = 0;
    fd6_cnt = 0;
    for (int i = 1; i <= 192; i++) begin
      step(1);
      if ($countones(~led_enable6) != 1 || sev_seg_leds6 != 8'hC0) bad6++;
      if (frame_done6) fd6_cnt++;
      if (i == 1)  check("six_restart_en", led_enable6, 6'b111110);
      if (i == 81) check("six_k81_en", led_enable6, 6'b011111);
      if (i == 96) check("six_k96_fd", frame_done6, 1'b1);
      if (i == 97) check("six_k97_en", led_enable6, 6'b111110);
    end
    check("six_scan_illegal", bad6, 0);
    check("six_fd_count", fd6_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan_n.md
SEV_SEG_SCAN_N -- requirements
Module: sev_seg_scan_n

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL provide parameter PRESCALE_W, default 15, prescaler width; one digit slot = 2^PRESCALE_W clk cycles.
REQ-003 SHALL provide parameter DUTY_W, default 3, brightness control width; PRESCALE_W >= DUTY_W+1.
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port load  input  1  one-cycle strobe capturing value/dp/blank_lz into the pending buffer.
REQ-007 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 rightmost.
REQ-008 SHALL have port dp  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-009 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-010 SHALL have port brightness  input  DUTY_W  on-time select; sampled live, not buffered.
REQ-011 SHALL have port sev_seg_leds  output  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
REQ-012 SHALL have port led_enable  output  NUM_DIGITS  active-low one-hot digit enable, registered.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at each frame wrap, registered.

Function
REQ-014 Prescaler SHALL be a PRESCALE_W-bit up-counter incrementing every cycle, wrapping all-ones -> 0; tick = counter all-ones.
REQ-015 Digit index SHALL advance by 1 on each tick, wrapping NUM_DIGITS-1 -> 0; non-power-of-2 NUM_DIGITS never reaches an illegal index.
REQ-016 frame_done SHALL assert for exactly the cycle after a tick that wraps the index to 0.
REQ-017 load SHALL write value/dp/blank_lz into the pending buffer and set pending_valid; a later load before transfer overwrites pending (last wins).
REQ-018 On a frame-wrap tick with pending_valid=1, pending SHALL copy to the active buffer and pending_valid clear; display never mixes two loads within one frame.
REQ-019 load coincident with a frame-wrap tick: the new data SHALL enter pending with pending_valid left set; active takes the prior pending contents if it was valid, else is unchanged.
REQ-020 Decoding SHALL use the active buffer only, full hex 0-F (A,b,C,d,E,F glyphs), segment bit 0 = on.
REQ-021 With active blank_lz=1, digit i (i>=1) SHALL be blanked when nibbles NUM_DIGITS-1..i are all zero; digit 0 never blanked.
REQ-022 A blanked digit SHALL drive a-g off (1) while dp follows its dp bit; enable still follows scan.
REQ-023 Duty: digit enable SHALL assert only while prescaler[PRESCALE_W-1 -: DUTY_W] <= brightness; brightness all-ones = 100 %, 0 = 1/2^DUTY_W.
REQ-024 When enable is off by duty, led_enable SHALL be all ones and sev_seg_leds 8'hFF.
REQ-025 Outputs SHALL lag the index/prescaler state by exactly one clk (registered); at most one led_enable bit low at any time.
REQ-026 brightness change SHALL take effect on the next cycle's duty compare with no other side effect.

Reset
REQ-027 reset=0 SHALL immediately (asynchronously) force prescaler 0, index 0, pending/active buffers 0, pending_valid 0.
REQ-028 During reset: sev_seg_leds = 8'hFF, led_enable = all ones, frame_done = 0.
REQ-029 After reset release, the first prescaler increment SHALL occur on the first rising clk edge; first displayed digit is digit 0 showing "0".
REQ-030 Reset asserted mid-frame or mid-slot SHALL discard pending data; no partial frame_done pulse emitted.

Verification (NUM_DIGITS=4, PRESCALE_W=4, DUTY_W=3 unless stated)
REQ-031 Reset release, no load -> led_enable cycles 1110,1101,1011,0111 every 16 clks, sev_seg_leds 8'hC0 ("0"), frame_done pulse every 64 clks.
REQ-032 load value=16'h12AF, dp=4'b0100, brightness=7 mid-frame -> display unchanged until next frame wrap; then digit0=8'h8E (F), digit1=8'h88 (A), digit2=8'h24 ("2"+dp), digit3=8'hF9 ("1").
REQ-033 blank_lz=1, value=16'h0005, dp=0 -> digits 3,2,1 drive 8'hFF segments with their enables still scanning; digit0 = 8'h92; value=16'h0000 -> digit0 shows 8'hC0.
REQ-034 brightness=0 -> each enable low 2 of 16 slot cycles; brightness=3 -> 8 of 16; brightness=7 -> 16 of 16.
REQ-035 Two loads (16'h1111 then 16'h2222) within one frame, plus a third load on the frame-wrap tick cycle -> next frame shows 2222, following frame shows third value.
REQ-036 NUM_DIGITS=6 with reset pulsed low mid-slot -> outputs go to all-off asynchronously, index restarts at 0, index never exceeds 5.
